// File: rtl/eth_mdio_pkg.sv
// Shared Clause 22 MDIO definitions: frame states, opcodes, register map and reset values.
package eth_mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST2,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA
    } mdio_state_e;

    localparam logic [1:0]  MDIO_OP_RD    = 2'b10;
    localparam logic [1:0]  MDIO_OP_WR    = 2'b01;

    localparam logic [4:0]  REG_BMCR      = 5'd0;
    localparam logic [4:0]  REG_BMSR      = 5'd1;
    localparam logic [4:0]  REG_ID1       = 5'd2;
    localparam logic [4:0]  REG_ID2       = 5'd3;
    localparam logic [4:0]  REG_ANAR      = 5'd4;
    localparam logic [4:0]  REG_SCRATCH   = 5'd31;

    localparam logic [15:0] BMCR_RST      = 16'h3100;
    localparam logic [15:0] BMSR_BASE     = 16'h7809;
    localparam logic [15:0] ANAR_RST      = 16'h01E1;
    localparam logic [15:0] SCRATCH_RST   = 16'h0000;

    localparam logic [5:0]  MDIO_PRE_LEN  = 6'd32;

    // Edge indices counted from the ST '0' edge.
    localparam logic [4:0]  EDGE_OP_END   = 5'd3;
    localparam logic [4:0]  EDGE_PHY_END  = 5'd8;
    localparam logic [4:0]  EDGE_REG_END  = 5'd13;
    localparam logic [4:0]  EDGE_TA1      = 5'd14;
    localparam logic [4:0]  EDGE_LAST     = 5'd31;

    function automatic logic [5:0] pre_sat_inc(input logic [5:0] cnt);
        if (cnt >= MDIO_PRE_LEN) begin
            return MDIO_PRE_LEN;
        end else begin
            return cnt + 6'd1;
        end
    endfunction

endpackage

// File: rtl/eth_mdio_phy_resp_edge_sync.sv
// Two-flop synchronizers for MDC/MDIO plus MDC rising-edge detect in the Clk domain.
module mdio_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise_o,
    output logic mdio_o
);

    logic [2:0] mdc_sync_q, mdc_sync_d;
    logic [1:0] mdio_sync_q, mdio_sync_d;

    // Next-state of the synchronizer chains.
    always_comb begin
        mdc_sync_d  = {mdc_sync_q[1:0], mdc_i};
        mdio_sync_d = {mdio_sync_q[0], mdio_i};
    end

    // Synchronizer flops; MDIO idles high on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_sync_q  <= 3'b000;
            mdio_sync_q <= 2'b11;
        end else begin
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
        end
    end

    assign mdc_rise_o = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign mdio_o     = mdio_sync_q[1];

endmodule

// File: rtl/eth_mdio_phy_resp.sv
// Clause 22 PHY-side MDIO responder with a small register file, oversampling MDC in Clk.
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN to accept ST after a single preamble '1'.
module eth_mdio_phy_resp
    import eth_mdio_pkg::*;
#(
    parameter logic [4:0]  gPhy_Addr = 5'h01,
    parameter logic [15:0] gPhy_Id1  = 16'h0007,
    parameter logic [15:0] gPhy_Id2  = 16'hC0F1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MDC,
    input  logic        MDIO_In,
    output logic        MDIO_Out,
    output logic        MDIO_Oe,
    input  logic        Link_Up,
    output logic        Reg_Wr_Strb,
    output logic [4:0]  Reg_Wr_Addr,
    output logic [15:0] Reg_Wr_Data
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic SUPPRESS = 1'b1;
`else
    localparam logic SUPPRESS = 1'b0;
`endif

    logic        mdc_rise_s, mdio_s, pre_ok_s, rd_match_s;
    logic [4:0]  cur_edge_s, regad_full_s;
    logic [15:0] rdata_s;

    mdio_state_e state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  edge_q, edge_d, phyad_q, phyad_d, regad_q, regad_d;
    logic [1:0]  op_q, op_d;
    logic        match_q, match_d, commit_q, commit_d;
    logic [15:0] shreg_q, shreg_d;
    logic        out_q, out_d, oe_q, oe_d, strb_q, strb_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d, reg0_q, reg0_d, reg4_q, reg4_d, reg31_q, reg31_d;

    mdio_edge_sync u_sync (
        .clk        (Clk),
        .rst        (Rst),
        .mdc_i      (MDC),
        .mdio_i     (MDIO_In),
        .mdc_rise_o (mdc_rise_s),
        .mdio_o     (mdio_s)
    );

    // Read mux, addressed by REGAD including the bit arriving on edge 13.
    always_comb begin
        regad_full_s = {regad_q[3:0], mdio_s};
        case (regad_full_s)
            REG_BMCR:    rdata_s = reg0_q;
            REG_BMSR:    rdata_s = BMSR_BASE | {9'd0, SUPPRESS, 3'd0, Link_Up, 2'd0};
            REG_ID1:     rdata_s = gPhy_Id1;
            REG_ID2:     rdata_s = gPhy_Id2;
            REG_ANAR:    rdata_s = reg4_q;
            REG_SCRATCH: rdata_s = reg31_q;
            default:     rdata_s = 16'h0000;
        endcase
    end

    // Frame decode, TA/read-data drive and write commit.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        edge_d    = edge_q;
        op_d      = op_q;
        phyad_d   = phyad_q;
        regad_d   = regad_q;
        match_d   = match_q;
        shreg_d   = shreg_q;
        out_d     = out_q;
        oe_d      = oe_q;
        commit_d  = 1'b0;
        strb_d    = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        reg0_d    = reg0_q;
        reg4_d    = reg4_q;
        reg31_d   = reg31_q;

        cur_edge_s = edge_q + 5'd1;
        rd_match_s = match_q & (op_q == MDIO_OP_RD);
        pre_ok_s   = SUPPRESS ? (pre_cnt_q != 6'd0) : (pre_cnt_q == MDIO_PRE_LEN);

        // Strobe is issued for any matched write, even to read-only registers.
        if (commit_q) begin
            strb_d  = 1'b1;
            waddr_d = regad_q;
            wdata_d = shreg_q;
            case (regad_q)
                REG_BMCR: begin
                    if (shreg_q[15]) begin
                        reg0_d  = BMCR_RST;
                        reg4_d  = ANAR_RST;
                        reg31_d = SCRATCH_RST;
                    end else begin
                        reg0_d  = {1'b0, shreg_q[14:0]};
                    end
                end
                REG_ANAR:    reg4_d  = shreg_q;
                REG_SCRATCH: reg31_d = shreg_q;
                default:     reg0_d  = reg0_q;
            endcase
        end else begin
            strb_d = 1'b0;
        end

        if (mdc_rise_s) begin
            case (state_q)
                IDLE: begin
                    if (mdio_s) begin
                        pre_cnt_d = pre_sat_inc(pre_cnt_q);
                    end else if (pre_ok_s) begin
                        state_d   = ST2;
                        edge_d    = 5'd0;
                        pre_cnt_d = 6'd0;
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end
                ST2: begin
                    edge_d = cur_edge_s;
                    if (mdio_s) begin
                        state_d = OP;
                    end else begin
                        state_d   = IDLE;
                        pre_cnt_d = 6'd0;
                    end
                end
                OP: begin
                    edge_d = cur_edge_s;
                    op_d   = {op_q[0], mdio_s};
                    if (cur_edge_s != EDGE_OP_END) begin
                        state_d = OP;
                    end else if (({op_q[0], mdio_s} == MDIO_OP_RD) || ({op_q[0], mdio_s} == MDIO_OP_WR)) begin
                        state_d = PHYAD;
                    end else begin
                        state_d   = IDLE;
                        pre_cnt_d = 6'd0;
                    end
                end
                PHYAD: begin
                    edge_d  = cur_edge_s;
                    phyad_d = {phyad_q[3:0], mdio_s};
                    if (cur_edge_s == EDGE_PHY_END) begin
                        match_d = ({phyad_q[3:0], mdio_s} == gPhy_Addr);
                        state_d = REGAD;
                    end else begin
                        state_d = PHYAD;
                    end
                end
                REGAD: begin
                    edge_d  = cur_edge_s;
                    regad_d = regad_full_s;
                    if (cur_edge_s == EDGE_REG_END) begin
                        shreg_d = rdata_s;
                        state_d = TA;
                    end else begin
                        state_d = REGAD;
                    end
                end
                TA: begin
                    edge_d = cur_edge_s;
                    if (cur_edge_s == EDGE_TA1) begin
                        oe_d  = rd_match_s;
                        out_d = ~rd_match_s;
                    end else if (rd_match_s) begin
                        out_d   = shreg_q[15];
                        shreg_d = {shreg_q[14:0], 1'b0};
                        state_d = DATA;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    edge_d = cur_edge_s;
                    if (cur_edge_s == EDGE_LAST) begin
                        shreg_d   = {shreg_q[14:0], mdio_s};
                        commit_d  = match_q & (op_q == MDIO_OP_WR);
                        oe_d      = 1'b0;
                        out_d     = 1'b1;
                        state_d   = IDLE;
                        pre_cnt_d = 6'd0;
                    end else if (rd_match_s) begin
                        out_d   = shreg_q[15];
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end else begin
                        shreg_d = {shreg_q[14:0], mdio_s};
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pre_cnt_d = 6'd0;
                    oe_d      = 1'b0;
                    out_d     = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, register file and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            pre_cnt_q <= 6'd0;
            edge_q    <= 5'd0;
            op_q      <= 2'b00;
            phyad_q   <= 5'd0;
            regad_q   <= 5'd0;
            match_q   <= 1'b0;
            commit_q  <= 1'b0;
            shreg_q   <= 16'h0000;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
            strb_q    <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 16'h0000;
            reg0_q    <= BMCR_RST;
            reg4_q    <= ANAR_RST;
            reg31_q   <= SCRATCH_RST;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            edge_q    <= edge_d;
            op_q      <= op_d;
            phyad_q   <= phyad_d;
            regad_q   <= regad_d;
            match_q   <= match_d;
            commit_q  <= commit_d;
            shreg_q   <= shreg_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            strb_q    <= strb_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            reg0_q    <= reg0_d;
            reg4_q    <= reg4_d;
            reg31_q   <= reg31_d;
        end
    end

    assign MDIO_Out    = out_q;
    assign MDIO_Oe     = oe_q;
    assign Reg_Wr_Strb = strb_q;
    assign Reg_Wr_Addr = waddr_q;
    assign Reg_Wr_Data = wdata_q;

endmodule

// File: tb/tb_eth_mdio_phy_resp.sv
// Bench for eth_mdio_phy_resp: MDIO master model, vector table, randomized frames vs register model.
module tb_eth_mdio_phy_resp;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic SUP = 1'b1;
`else
    localparam logic SUP = 1'b0;
`endif
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b01;

    logic        Clk, Rst, MDC, Link_Up;
    logic        m_drv, m_val, mdio_line;
    logic        MDIO_Out, MDIO_Oe, Reg_Wr_Strb;
    logic [4:0]  Reg_Wr_Addr;
    logic [15:0] Reg_Wr_Data;

    int checks   = 0;
    int failures = 0;
    int strb_cnt = 0;
    logic [4:0]  strb_addr;
    logic [15:0] strb_data;

    logic [15:0] m_reg0, m_reg4, m_reg31;

    assign mdio_line = MDIO_Oe ? MDIO_Out : (m_drv ? m_val : 1'b1);

    eth_mdio_phy_resp dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .MDC         (MDC),
        .MDIO_In     (mdio_line),
        .MDIO_Out    (MDIO_Out),
        .MDIO_Oe     (MDIO_Oe),
        .Link_Up     (Link_Up),
        .Reg_Wr_Strb (Reg_Wr_Strb),
        .Reg_Wr_Addr (Reg_Wr_Addr),
        .Reg_Wr_Data (Reg_Wr_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Reg_Wr_Strb === 1'b1) begin
            strb_cnt  <= strb_cnt + 1;
            strb_addr <= Reg_Wr_Addr;
            strb_data <= Reg_Wr_Data;
        end
    end

    typedef struct {
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic        link;
        logic        resp;
        logic [15:0] rd;
        logic        strb;
    } vec_t;

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, what, act, exp);
        end
    endtask

    // One MDC period: master drives on the low phase, sample is taken just before the rise.
    task automatic mdc_bit(input logic drv, input logic val, output logic o, output logic l);
        MDC   = 1'b0;
        m_drv = drv;
        m_val = val;
        repeat (5) @(negedge Clk);
        o   = MDIO_Oe;
        l   = mdio_line;
        MDC = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    // s_oe[k]/s_ln[k] hold what was on the bus just before edge k (index 32 = after edge 31).
    task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] wd, input int rst_edge,
                             output logic [32:0] s_oe, output logic [32:0] s_ln);
        logic [31:0] bits;
        logic o, l, rdop;
        bits = {2'b01, op, phy, ra, 2'b10, wd};
        rdop = (op == RD);
        for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, o, l);
        for (int k = 0; k < 32; k++) begin
            mdc_bit(!(rdop && k >= 14), bits[31-k], o, l);
            s_oe[k] = o;
            s_ln[k] = l;
            if (k == rst_edge) begin
                chk("rst", "oe_before", {31'd0, MDIO_Oe}, 32'd1);
                Rst = 1'b1;
                #1;
                chk("rst", "oe_now", {31'd0, MDIO_Oe}, 32'd0);
                chk("rst", "out_now", {31'd0, MDIO_Out}, 32'd1);
                repeat (2) @(negedge Clk);
                Rst = 1'b0;
            end
        end
        mdc_bit(1'b0, 1'b1, o, l);
        s_oe[32] = o;
        s_ln[32] = l;
        mdc_bit(1'b0, 1'b1, o, l);
    endtask

    task automatic apply(input string nm, input vec_t v);
        logic [32:0] so, sl;
        logic [15:0] rdv;
        int c0;
        Link_Up = v.link;
        c0 = strb_cnt;
        run_frame(v.pre, v.op, v.phy, v.ra, v.wd, -1, so, sl);
        for (int j = 0; j < 16; j++) rdv[15-j] = sl[16+j];
        if (v.resp) begin
            chk(nm, "ta1_oe", {31'd0, so[14]}, 32'd0);
            chk(nm, "ta2_oe", {31'd0, so[15]}, 32'd1);
            chk(nm, "ta2_val", {31'd0, sl[15]}, 32'd0);
            chk(nm, "data_oe", {31'd0, &so[31:16]}, 32'd1);
            chk(nm, "rdata", {16'd0, rdv}, {16'd0, v.rd});
            chk(nm, "end_oe", {31'd0, so[32]}, 32'd0);
        end else begin
            chk(nm, "no_drive", {31'd0, |so}, 32'd0);
        end
        chk(nm, "strb_cnt", strb_cnt - c0, {31'd0, v.strb});
        if (v.strb) begin
            chk(nm, "wr_addr", {27'd0, strb_addr}, {27'd0, v.ra});
            chk(nm, "wr_data", {16'd0, strb_data}, {16'd0, v.wd});
        end
    endtask

    function automatic vec_t mk(input int pre, input logic [1:0] op, input logic [4:0] phy,
                                input logic [4:0] ra, input logic [15:0] wd, input logic link,
                                input logic resp, input logic [15:0] rd, input logic strb);
        vec_t v;
        v.pre = pre; v.op = op; v.phy = phy; v.ra = ra; v.wd = wd;
        v.link = link; v.resp = resp; v.rd = rd; v.strb = strb;
        return v;
    endfunction

    function automatic logic [15:0] model_rd(input logic [4:0] ra, input logic lk);
        case (ra)
            5'd0:    return m_reg0;
            5'd1:    return 16'h7809 + (lk ? 16'h0004 : 16'h0000) + (SUP ? 16'h0040 : 16'h0000);
            5'd2:    return 16'h0007;
            5'd3:    return 16'hC0F1;
            5'd4:    return m_reg4;
            5'd31:   return m_reg31;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_reg0  = 16'h3100;
        m_reg4  = 16'h01E1;
        m_reg31 = 16'h0000;
    endtask

    task automatic model_wr(input logic [4:0] ra, input logic [15:0] d);
        if (ra == 5'd0 && d[15]) model_reset();
        else if (ra == 5'd0) m_reg0 = d & 16'h7FFF;
        else if (ra == 5'd4) m_reg4 = d;
        else if (ra == 5'd31) m_reg31 = d;
    endtask

    vec_t tbl [15];

    initial begin
        logic [32:0] so, sl;
        vec_t v;
        logic [4:0] ra;
        Rst = 1'b1; MDC = 1'b0; m_drv = 1'b0; m_val = 1'b1; Link_Up = 1'b0;
        repeat (5) @(negedge Clk);
        chk("reset", "oe", {31'd0, MDIO_Oe}, 32'd0);
        chk("reset", "out", {31'd0, MDIO_Out}, 32'd1);
        chk("reset", "strb", {31'd0, Reg_Wr_Strb}, 32'd0);
        chk("reset", "addr", {27'd0, Reg_Wr_Addr}, 32'd0);
        chk("reset", "data", {16'd0, Reg_Wr_Data}, 32'd0);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);

        tbl[0]  = mk(32, RD, 5'd1, 5'd2,  16'h0000, 1'b0, 1'b1, 16'h0007, 1'b0);
        tbl[1]  = mk(32, WR, 5'd1, 5'd31, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b1);
        tbl[2]  = mk(32, RD, 5'd1, 5'd31, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        tbl[3]  = mk(32, WR, 5'd1, 5'd31, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1);
        tbl[4]  = mk(32, WR, 5'd1, 5'd0,  16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        tbl[5]  = mk(32, RD, 5'd1, 5'd31, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
        tbl[6]  = mk(32, RD, 5'd1, 5'd0,  16'h0000, 1'b0, 1'b1, 16'h3100, 1'b0);
        tbl[7]  = mk(32, RD, 5'd2, 5'd1,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        tbl[8]  = mk(32, RD, 5'd1, 5'd1,  16'h0000, 1'b1, 1'b1, 16'h780D | (SUP ? 16'h0040 : 16'h0000), 1'b0);
        tbl[9]  = mk(20, RD, 5'd1, 5'd1,  16'h0000, 1'b0, SUP,  16'h7849, 1'b0);
        tbl[10] = mk(40, RD, 5'd1, 5'd3,  16'h0000, 1'b0, 1'b1, 16'hC0F1, 1'b0);
        tbl[11] = mk(32, WR, 5'd1, 5'd0,  16'h1200, 1'b0, 1'b0, 16'h0000, 1'b1);
        tbl[12] = mk(32, RD, 5'd1, 5'd0,  16'h0000, 1'b0, 1'b1, 16'h1200, 1'b0);
        tbl[13] = mk(32, WR, 5'd1, 5'd2,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1);
        tbl[14] = mk(32, WR, 5'd3, 5'd31, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 15; i++) apply($sformatf("vec%0d", i), tbl[i]);
        apply("ro_id1", mk(32, RD, 5'd1, 5'd2, 16'h0000, 1'b0, 1'b1, 16'h0007, 1'b0));

        // Bring the register file back to defaults before the randomized phase.
        apply("softrst", mk(33, WR, 5'd1, 5'd0, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1));
        model_reset();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: ra = 5'd0;
                1: ra = 5'd1;
                2: ra = 5'd2;
                3: ra = 5'd3;
                4: ra = 5'd4;
                5: ra = 5'd31;
                default: ra = 5'($urandom_range(0, 31));
            endcase
            v.pre  = 32 + int'($urandom_range(0, 4));
            v.op   = ($urandom_range(0, 1) == 0) ? RD : WR;
            v.phy  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
            v.ra   = ra;
            v.wd   = 16'($urandom_range(0, 65535));
            v.link = 1'($urandom_range(0, 1));
            v.resp = (v.phy == 5'd1) && (v.op == RD);
            v.strb = (v.phy == 5'd1) && (v.op == WR);
            v.rd   = model_rd(v.ra, v.link);
            apply($sformatf("rnd%0d", n), v);
            if (v.strb) model_wr(v.ra, v.wd);
        end

        // Reset in the middle of a matched read, then confirm defaults.
        apply("pre_rst_wr", mk(32, WR, 5'd1, 5'd31, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b1));
        Link_Up = 1'b0;
        run_frame(32, RD, 5'd1, 5'd0, 16'h0000, 20, so, sl);
        apply("post_rst_r0", mk(32, RD, 5'd1, 5'd0, 16'h0000, 1'b0, 1'b1, 16'h3100, 1'b0));
        apply("post_rst_r31", mk(32, RD, 5'd1, 5'd31, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
